// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver (and the matching transmitter):
//   - rx_state_t : receiver FSM states
//   - PAR_EVEN / PAR_ODD : encodings of the PAR_TYPE input
//   - calc_parity() : parity bit for a data word, used on both ends of the link
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest word the parity helper accepts; callers zero-extend their data,
    // which leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W = 64;

    // Even: parity = ^data. Odd: parity = ~^data.
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data,
                                         input logic                 par_type);
        return (^data) ^ par_type;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling counter and 3-sample majority vote.
//   i_clk         : oversampling clock
//   i_rst_n       : asynchronous active-low reset
//   i_active      : high while a frame is being received; low holds edge_cnt at 0
//   i_rx          : serial line (already synchronised)
//   i_presc       : clocks per bit, captured by the FSM at start detection
//   o_bit         : majority-voted value of the current bit (registered)
//   o_sample_done : one-cycle strobe, high in the cycle after o_bit is updated
//   o_bit_end     : high while edge_cnt = P-1 (last clock of the bit)
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_active,
    input  logic               i_rx,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_bit,
    output logic               o_sample_done,
    output logic               o_bit_end
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] r_edge_cnt;
    logic               r_s1;
    logic               r_s2;
    logic               r_bit;
    logic               r_done;

    logic [PRESC_W-1:0] w_half;
    logic               w_vote;
    logic               w_bit_end;

    assign w_half    = i_presc >> 1;
    assign w_bit_end = i_active && (r_edge_cnt == (i_presc - ONE));
    // Third sample is the live line value at edge_cnt = P/2+1.
    assign w_vote    = (r_s1 & r_s2) | (r_s1 & i_rx) | (r_s2 & i_rx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_edge_cnt <= '0;
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_bit      <= 1'b1;
            r_done     <= 1'b0;
        end else if (!i_active) begin
            // The edge that detects a start bit is counted as edge_cnt 0,
            // so the counter must be sitting at 0 afterwards.
            r_edge_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + ONE;
            r_done     <= 1'b0;
            if (r_edge_cnt == (w_half - ONE)) begin
                r_s1 <= i_rx;
            end
            if (r_edge_cnt == w_half) begin
                r_s2 <= i_rx;
            end
            if (r_edge_cnt == (w_half + ONE)) begin
                r_bit  <= w_vote;
                r_done <= 1'b1;
            end
        end
    end

    assign o_bit         = r_bit;
    assign o_sample_done = r_done;
    assign o_bit_end     = w_bit_end;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit, WIDTH data bits LSB first, optional parity, one
// stop bit. The line is oversampled PRESCALE times per bit.
//   CLK        : oversampling clock
//   RST        : asynchronous active-low reset
//   RX_IN      : serial line, idle high, already synchronised
//   PAR_EN     : frame carries a parity bit
//   PAR_TYPE   : 0 even, 1 odd
//   PRESCALE   : clocks per bit (8, 16 or 32)
//   P_DATA     : last correctly received word
//   DATA_VALID : one-cycle pulse when P_DATA is updated
//   PAR_ERR    : one-cycle pulse when a frame is dropped for bad parity
//   STP_ERR    : one-cycle pulse when a frame is dropped for a bad stop bit
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYPE,
    input  logic [PRESC_W-1:0] PRESCALE,
    output logic [WIDTH-1:0]   P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int             BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    rx_state_t          r_state;
    rx_state_t          w_state_next;

    logic [BCW-1:0]     r_bit_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_data;
    logic               r_par_en;
    logic               r_par_type;
    logic [PRESC_W-1:0] r_presc;
    logic               r_par_fail;
    logic               r_stop_bad;
    logic               r_valid;
    logic               r_par_err;
    logic               r_stp_err;

    logic               w_bit;
    logic               w_done;
    logic               w_bit_end;
    logic               w_active;
    logic               w_start_det;
    logic               w_valid_next;
    logic               w_par_err_next;
    logic               w_stp_err_next;

    assign w_active = (r_state != IDLE);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .i_clk         (CLK),
        .i_rst_n       (RST),
        .i_active      (w_active),
        .i_rx          (RX_IN),
        .i_presc       (r_presc),
        .o_bit         (w_bit),
        .o_sample_done (w_done),
        .o_bit_end     (w_bit_end)
    );

    // Next state, start detection and end-of-frame result pulses.
    always_comb begin
        w_state_next   = r_state;
        w_start_det    = 1'b0;
        w_valid_next   = 1'b0;
        w_par_err_next = 1'b0;
        w_stp_err_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (!RX_IN) begin
                    w_state_next = START;
                    w_start_det  = 1'b1;
                end
            end
            START: begin
                if (w_done && w_bit) begin
                    w_state_next = IDLE;    // start bit was a glitch
                end else if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
                    w_state_next = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_stp_err_next = r_stop_bad;
                    w_par_err_next = !r_stop_bad && r_par_fail;
                    w_valid_next   = !r_stop_bad && !r_par_fail;
                    // A start bit already on the line at the last stop clock
                    // begins the next frame on this very edge.
                    if (!RX_IN) begin
                        w_state_next = START;
                        w_start_det  = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= PAR_EVEN;
            r_presc    <= '0;
            r_par_fail <= 1'b0;
            r_stop_bad <= 1'b0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else begin
            r_valid   <= w_valid_next;
            r_par_err <= w_par_err_next;
            r_stp_err <= w_stp_err_next;
            if (w_valid_next) begin
                r_data <= r_shift;
            end

            // Frame configuration is frozen for the whole frame.
            if (w_start_det) begin
                r_par_en   <= PAR_EN;
                r_par_type <= PAR_TYPE;
                r_presc    <= PRESCALE;
                r_par_fail <= 1'b0;
                r_stop_bad <= 1'b0;
                r_bit_cnt  <= '0;
            end

            if ((r_state == DATA) && w_done) begin
                r_shift[r_bit_cnt] <= w_bit;
            end
            if ((r_state == DATA) && w_bit_end) begin
                r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BCW'(1);
            end

            if ((r_state == PARITY) && w_done) begin
                r_par_fail <= (w_bit != calc_parity(PAR_MAX_W'(r_shift), r_par_type));
            end
            if ((r_state == STOP) && w_done) begin
                r_stop_bad <= !w_bit;
            end
        end
    end

    assign P_DATA     = r_data;
    assign DATA_VALID = r_valid;
    assign PAR_ERR    = r_par_err;
    assign STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. Frames are driven bit by bit from the bench;
// a monitor logs every cycle in which a result pulse is high together with
// the cycle number, and each test compares that log with hand-derived values.
// Cycle numbering: cyc counts rising edges; t0 is the first edge that sees the
// start bit, and a frame's pulse must be seen right after edge t0 + N*P.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 6;

    logic               CLK      = 1'b0;
    logic               RST      = 1'b0;
    logic               RX_IN    = 1'b1;
    logic               PAR_EN   = 1'b0;
    logic               PAR_TYPE = 1'b0;
    logic [PRESC_W-1:0] PRESCALE = 6'd8;
    logic [WIDTH-1:0]   P_DATA;
    logic               DATA_VALID;
    logic               PAR_ERR;
    logic               STP_ERR;

    uart_rx #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYPE   (PAR_TYPE),
        .PRESCALE   (PRESCALE),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       v;
        logic       pe;
        logic       se;
    } ev_t;

    ev_t evq[$];

    always @(posedge CLK) begin
        #1;
        if (DATA_VALID || PAR_ERR || STP_ERR) begin
            evq.push_back('{c: cyc, d: P_DATA, v: DATA_VALID, pe: PAR_ERR, se: STP_ERR});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one frame starting at #1 after a rising edge. gbit/gofs invert the
    // line for one clock (frame bit index, clock within the bit); -1 disables.
    // The configuration inputs are scrambled after the start edge to show that
    // the frame keeps the values captured at start detection.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptype, input logic pbit, input logic sbit,
                              input int gbit, input int gofs, output int t0);
        int nb;
        PRESCALE = PRESC_W'(p);
        PAR_EN   = pen;
        PAR_TYPE = ptype;
        t0 = cyc + 1;
        nb = 10 + int'(pen);
        $display("frame data=0x%02h P=%0d par_en=%0d par_type=%0d par_bit=%0d stop=%0d t0=%0d",
                 d, p, pen, ptype, pbit, sbit, t0);
        for (int b = 0; b < nb; b++) begin
            logic v;
            if (b == 0)              v = 1'b0;
            else if (b <= 8)         v = d[b-1];
            else if (pen && b == 9)  v = pbit;
            else                     v = sbit;
            for (int k = 0; k < p; k++) begin
                RX_IN = (b == gbit && k == gofs) ? ~v : v;
                if (b == 0 && k == 1) begin
                    PAR_EN   = ~pen;
                    PAR_TYPE = ~ptype;
                    PRESCALE = (p == 8) ? 6'd16 : 6'd8;
                end
                @(posedge CLK);
                #1;
            end
        end
        PRESCALE = PRESC_W'(p);
        PAR_EN   = pen;
        PAR_TYPE = ptype;
    endtask

    // Pops one logged pulse and compares it; an empty log yields c = -1.
    task automatic expect_ev(input string tag, input int exp_c, input logic [7:0] d,
                             input logic v, input logic pe, input logic se);
        ev_t e;
        e = '{c: -1, d: 8'hxx, v: 1'bx, pe: 1'bx, se: 1'bx};
        if (evq.size() > 0) e = evq.pop_front();
        check_val({tag, " cycle"}, e.c, exp_c);
        check_val({tag, " data"},  {24'd0, e.d}, {24'd0, d});
        check_val({tag, " flags"}, {29'd0, e.v, e.pe, e.se}, {29'd0, v, pe, se});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, t2;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_val("reset p_data", {24'd0, P_DATA}, 32'h00);
        check_val("reset valid",  {31'd0, DATA_VALID}, 32'd0);
        check_val("reset par_err", {31'd0, PAR_ERR}, 32'd0);
        check_val("reset stp_err", {31'd0, STP_ERR}, 32'd0);
        RST = 1'b1;
        idle(6);
        evq.delete();

        // 1: P=8, no parity, 0xA5 -> pulse at t0+80
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, t0);
        idle(20);
        check_val("t1 count", evq.size(), 1);
        expect_ev("t1", t0 + 80, 8'hA5, 1'b1, 1'b0, 1'b0);
        check_val("t1 hold", {24'd0, P_DATA}, 32'hA5);

        // 2: P=16, even parity, 0x3C has four ones -> parity bit 0; t0+176
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, t0);
        idle(20);
        check_val("t2a count", evq.size(), 1);
        expect_ev("t2a", t0 + 176, 8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, t0);
        idle(20);
        check_val("t2b count", evq.size(), 1);
        expect_ev("t2b", t0 + 176, 8'h3C, 1'b0, 1'b1, 1'b0);

        // 3: P=8, odd parity, 0x81 (two ones -> parity bit 1), stop driven 0
        send_frame(8'h81, 8, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0, t0);
        idle(20);
        check_val("t3a count", evq.size(), 1);
        expect_ev("t3a", t0 + 88, 8'h3C, 1'b0, 1'b0, 1'b1);
        // bad parity and bad stop together: stop error wins
        send_frame(8'h81, 8, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0, t0);
        idle(20);
        check_val("t3b count", evq.size(), 1);
        expect_ev("t3b", t0 + 88, 8'h3C, 1'b0, 1'b0, 1'b1);

        // 4: P=32, 10-cycle low pulse is rejected as a glitch
        PRESCALE = 6'd32;
        RX_IN = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        idle(400);
        check_val("t4a glitch pulses", evq.size(), 0);
        // one-cycle 0 at the mid sample of data bit 4 (value 1) is outvoted
        send_frame(8'hF0, 32, 1'b0, 1'b0, 1'b0, 1'b1, 5, 17, t0);
        idle(40);
        check_val("t4b count", evq.size(), 1);
        expect_ev("t4b", t0 + 320, 8'hF0, 1'b1, 1'b0, 1'b0);

        // 5: back-to-back frames, no idle gap, P=8
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, t0);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, t1);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, t2);
        idle(20);
        check_val("t5 count", evq.size(), 3);
        expect_ev("t5 f0", t0 + 80, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_ev("t5 f1", t1 + 80, 8'hFF, 1'b1, 1'b0, 1'b0);
        expect_ev("t5 f2", t2 + 80, 8'h5A, 1'b1, 1'b0, 1'b0);

        // 6: reset mid-frame (during data bit 4 of 0xF0; the rest of the
        //    frame is all ones, so nothing restarts), then a clean 0x11
        fork
            send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, t0);
            begin
                repeat (42) @(posedge CLK);
                #3;
                RST = 1'b0;
                #1;
                check_val("t6 rst p_data", {24'd0, P_DATA}, 32'h00);
                check_val("t6 rst flags", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
                repeat (2) @(posedge CLK);
                #3;
                RST = 1'b1;
            end
        join
        idle(30);
        check_val("t6 aborted pulses", evq.size(), 0);
        check_val("t6 p_data after abort", {24'd0, P_DATA}, 32'h00);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, t0);
        idle(20);
        check_val("t6 count", evq.size(), 1);
        expect_ev("t6", t0 + 80, 8'h11, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
